ramwb_pipe: RTL and testbench

RAMWB_PIPE -- requirements
Module: ramwb_pipe

---
 rtl/ramwb_pipe.sv | 166 ++++++++++++++++
 tb/tb_ramwb_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramwb_pipe.sv
// Pipelined Wishbone-style RAM/ROM bridge: validates byte/half/word requests,
// drives a synchronous memory, and returns in-order ack/err after LATENCY cycles.
module ramwb_pipe #(
  parameter int unsigned SIZE_BYTE  = 4096,
  parameter logic [31:0] START_ADDR = 32'h2000_0000,
  parameter int unsigned LATENCY    = 1,
  parameter bit          WRITABLE   = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_cyc,
  input  logic                         i_stb,
  input  logic [31:0]                  i_addr,
  input  logic                         i_we,
  input  logic [3:0]                   i_sel,
  input  logic [31:0]                  i_data,
  output logic                         o_ack,
  output logic                         o_err,
  output logic [31:0]                  o_data,
  output logic                         o_stall,
  output logic                         o_mem_en,
  output logic [3:0]                   o_mem_we,
  output logic [$clog2(SIZE_BYTE)-3:0] o_mem_addr,
  output logic [31:0]                  o_mem_wd,
  input  logic [31:0]                  i_mem_rd
);
  localparam int unsigned AW      = $clog2(SIZE_BYTE);
  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b11;
  localparam logic [32:0] LO_ADDR = {1'b0, START_ADDR};
  localparam logic [32:0] HI_ADDR = LO_ADDR + 33'(SIZE_BYTE);

  typedef struct packed {
    logic       valid;
    logic       err;
    logic       we;
    logic [1:0] size;
    logic [1:0] off;
  } stage_t;

  if (SIZE_BYTE < 8 || (SIZE_BYTE & (SIZE_BYTE - 1)) != 0) begin : g_bad_size
    $fatal(1, "ramwb_pipe: SIZE_BYTE must be a power of two >= 8");
  end
  if ((START_ADDR & 32'(SIZE_BYTE - 1)) != 32'd0) begin : g_bad_start
    $fatal(1, "ramwb_pipe: START_ADDR must be aligned to SIZE_BYTE");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $fatal(1, "ramwb_pipe: LATENCY must be in 1..4");
  end

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b1;
      SZ_HALF: r = ~off[0];
      SZ_WORD: r = (off == 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = 4'b0011 << off;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_repl(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{d[7:0]}};
      SZ_HALF: r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {24'd0, rd[{off, 3'b000} +: 8]};
      SZ_HALF: r = off[1] ? {16'd0, rd[31:16]} : {16'd0, rd[15:0]};
      SZ_WORD: r = rd;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic                      req_s;
  logic                      in_range_s;
  logic                      valid_s;
  logic                      unused_sel_s;
  stage_t                    new_s;
  stage_t                    head_s;
  stage_t [LATENCY-1:0]      stage_d;
  stage_t [LATENCY-1:0]      stage_q;

  assign unused_sel_s = i_sel[3] ^ i_sel[0];
  assign req_s        = i_rst_n & i_cyc & i_stb;
  assign in_range_s   = ({1'b0, i_addr} >= LO_ADDR) && ({1'b0, i_addr} < HI_ADDR);
  assign valid_s      = is_aligned(i_sel[2:1], i_addr[1:0]) & in_range_s & (~i_we | WRITABLE);
  assign o_mem_addr   = i_addr[AW-1:2];
  assign o_stall      = 1'b0;
  assign head_s       = stage_q[LATENCY-1];

  // Memory port: only valid requests touch the array; lanes come from size/offset.
  always_comb begin
    o_mem_en = req_s & valid_s;
    o_mem_we = 4'b0000;
    o_mem_wd = 32'd0;
    if (o_mem_en && i_we) begin
      o_mem_we = lane_mask(i_sel[2:1], i_addr[1:0]);
      o_mem_wd = lane_repl(i_sel[2:1], i_data);
    end else begin
      o_mem_we = 4'b0000;
      o_mem_wd = 32'd0;
    end
  end

  // Response pipeline next state; dropping i_cyc abandons every in-flight entry.
  always_comb begin
    new_s       = '0;
    stage_d     = '0;
    new_s.valid = i_cyc & i_stb;
    new_s.err   = ~valid_s;
    new_s.we    = i_we;
    new_s.size  = i_sel[2:1];
    new_s.off   = i_addr[1:0];
    if (i_cyc) begin
      stage_d[0] = new_s;
      for (int i = 1; i < LATENCY; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end else begin
      stage_d = '0;
    end
  end

  // Response pipeline register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Head-of-pipe response; i_cyc gates it so a same-cycle abort suppresses it.
  always_comb begin
    o_ack  = i_cyc & head_s.valid & ~head_s.err;
    o_err  = i_cyc & head_s.valid & head_s.err;
    o_data = 32'd0;
    if (o_ack && !head_s.we) begin
      o_data = lane_extract(head_s.size, head_s.off, i_mem_rd);
    end else begin
      o_data = 32'd0;
    end
  end
endmodule

// File: tb/tb_ramwb_pipe.sv
// Bench for ramwb_pipe: three instances (LATENCY 1/3/2, the last one ROM) share one
// bus; a byte-level reference memory feeds a scoreboard of expected responses.
module tb_ramwb_pipe;
  localparam logic [31:0] START = 32'h2000_0000;
  localparam int          SIZE  = 4096;

  typedef struct {
    int          k;
    bit          err;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        ack_s   [3];
  logic        err_s   [3];
  logic        stall_s [3];
  logic        men_s   [3];
  logic [31:0] rdata_s [3];
  logic [31:0] mwd_s   [3];
  logic [31:0] mrd_s   [3];
  logic [3:0]  mwe_s   [3];
  logic [9:0]  maddr_s [3];

  int   checks = 0;
  int   errors = 0;
  int   cycn   = 0;
  exp_t sbq[$];
  logic [7:0] refm [3][SIZE];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit wr_of(input int k);
    return (k != 2);
  endfunction

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0307);
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycn <= cycn + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT_G = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    localparam bit WR_G  = (g != 2);
    logic [31:0] mem [1024];
    logic [31:0] rdp [4];

    ramwb_pipe #(
      .SIZE_BYTE (4096),
      .START_ADDR(START),
      .LATENCY   (LAT_G),
      .WRITABLE  (WR_G)
    ) u_dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_cyc     (cyc),
      .i_stb     (stb),
      .i_addr    (addr),
      .i_we      (we),
      .i_sel     (sel),
      .i_data    (wdata),
      .o_ack     (ack_s[g]),
      .o_err     (err_s[g]),
      .o_data    (rdata_s[g]),
      .o_stall   (stall_s[g]),
      .o_mem_en  (men_s[g]),
      .o_mem_we  (mwe_s[g]),
      .o_mem_addr(maddr_s[g]),
      .o_mem_wd  (mwd_s[g]),
      .i_mem_rd  (mrd_s[g])
    );

    initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end

    // Synchronous memory with LAT_G cycles of read latency.
    always @(posedge clk) begin
      if (men_s[g]) begin
        for (int b = 0; b < 4; b++) begin
          if (mwe_s[g][b]) mem[maddr_s[g]][8*b +: 8] <= mwd_s[g][8*b +: 8];
        end
      end
      rdp[0] <= mem[maddr_s[g]];
      for (int i = 1; i < 4; i++) rdp[i] <= rdp[i-1];
    end
    assign mrd_s[g] = rdp[LAT_G-1];
  end

  // One bus cycle: drive, predict responses, then score every instance mid-cycle.
  task automatic drive(input bit c, input bit s, input bit w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   nb;
    int   bo;
    bit   al;
    bit   inr;
    int   hit;
    @(posedge clk);
    #1;
    cyc = c; stb = s; we = w; sel = {1'b0, sz, 1'b0}; addr = a; wdata = d;
    if (!c) begin
      sbq.delete();
    end else if (s) begin
      nb = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
      case (sz)
        2'b00:   al = 1'b1;
        2'b01:   al = (a[0] == 1'b0);
        2'b11:   al = (a[1:0] == 2'b00);
        default: al = 1'b0;
      endcase
      inr = (a >= START) && (a < START + 32'(SIZE));
      bo  = int'(a - START);
      for (int k = 0; k < 3; k++) begin
        e.k    = k;
        e.err  = !(al && inr && (!w || wr_of(k)));
        e.data = 32'd0;
        e.due  = cycn + lat_of(k);
        if (!e.err) begin
          for (int j = 0; j < nb; j++) begin
            if (w) refm[k][bo+j] = d[8*j +: 8];
            else   e.data[8*j +: 8] = refm[k][bo+j];
          end
        end
        sbq.push_back(e);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      hit = -1;
      foreach (sbq[i]) if (sbq[i].k == k && sbq[i].due == cycn) hit = i;
      checks++;
      if (hit >= 0) begin
        e = sbq[hit];
        sbq.delete(hit);
        if (ack_s[k] !== !e.err || err_s[k] !== e.err || rdata_s[k] !== e.data) begin
          errors++;
          $display("FAIL resp inst%0d cycle %0d: ack=%0b err=%0b data=%h, want ack=%0b err=%0b data=%h",
                   k, cycn, ack_s[k], err_s[k], rdata_s[k], !e.err, e.err, e.data);
        end
      end else if (ack_s[k] !== 1'b0 || err_s[k] !== 1'b0 || rdata_s[k] !== 32'd0) begin
        errors++;
        $display("FAIL idle inst%0d cycle %0d: ack=%0b err=%0b data=%h, want 0 0 0",
                 k, cycn, ack_s[k], err_s[k], rdata_s[k]);
      end
      checks++;
      if (stall_s[k] !== 1'b0) begin
        errors++;
        $display("FAIL stall inst%0d: got %0b want 0", k, stall_s[k]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 2'b11, START, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b0110; addr = START; wdata = 32'h1;
    #2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ack_s[k] !== 1'b0 || err_s[k] !== 1'b0 || rdata_s[k] !== 32'd0 ||
          men_s[k] !== 1'b0 || mwe_s[k] !== 4'b0000) begin
        errors++;
        $display("FAIL reset inst%0d: ack=%0b err=%0b data=%h en=%0b we=%b, want all zero",
                 k, ack_s[k], err_s[k], rdata_s[k], men_s[k], mwe_s[k]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    idle(2);
  endtask

  task automatic test_word_rw();
    drive(1'b1, 1'b1, 1'b1, 2'b11, START + 32'd4, 32'hDEAD_BEEF);
    checks++;
    if (men_s[0] !== 1'b1 || mwe_s[0] !== 4'b1111 || mwd_s[0] !== 32'hDEAD_BEEF || maddr_s[0] !== 10'd1) begin
      errors++;
      $display("FAIL word_wr port: en=%0b we=%b wd=%h ad=%0d, want 1 1111 deadbeef 1",
               men_s[0], mwe_s[0], mwd_s[0], maddr_s[0]);
    end
    checks++;
    if (men_s[2] !== 1'b0 || mwe_s[2] !== 4'b0000) begin
      errors++;
      $display("FAIL rom_wr port: en=%0b we=%b, want 0 0000", men_s[2], mwe_s[2]);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b11, START + 32'd4, 32'd0);
    checks++;
    if (men_s[0] !== 1'b1 || mwe_s[0] !== 4'b0000) begin
      errors++;
      $display("FAIL word_rd port: en=%0b we=%b, want 1 0000", men_s[0], mwe_s[0]);
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b1, 2'b11, START + 32'h10, 32'hAABB_CCDD);
    idle(1);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 2'b00, START + 32'h10 + 32'(i), 32'd0);
    idle(4);
  endtask

  task automatic test_half();
    drive(1'b1, 1'b1, 1'b1, 2'b01, START + 32'h22, 32'h0000_1234);
    checks++;
    if (mwe_s[0] !== 4'b1100 || mwd_s[0][31:16] !== 16'h1234) begin
      errors++;
      $display("FAIL half_wr port: we=%b wd=%h, want 1100 1234xxxx", mwe_s[0], mwd_s[0]);
    end
    drive(1'b1, 1'b1, 1'b0, 2'b01, START + 32'h22, 32'd0);
    idle(4);
  endtask

  task automatic test_errors();
    logic [31:0] ea [4];
    logic [1:0]  es [4];
    ea[0] = START + 32'h31;       es[0] = 2'b01;
    ea[1] = START + 32'h30;       es[1] = 2'b10;
    ea[2] = START + 32'(SIZE);    es[2] = 2'b11;
    ea[3] = START - 32'd1;        es[3] = 2'b00;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 1'b0, es[c], ea[c], 32'd0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (men_s[k] !== 1'b0) begin
          errors++;
          $display("FAIL err_en case%0d inst%0d: en=%0b want 0", c, k, men_s[k]);
        end
      end
    end
    drive(1'b1, 1'b1, 1'b1, 2'b11, START + 32'h40, 32'h1357_9BDF);
    checks++;
    if (men_s[2] !== 1'b0 || men_s[0] !== 1'b1) begin
      errors++;
      $display("FAIL rom_write en: rom=%0b ram=%0b, want 0 1", men_s[2], men_s[0]);
    end
    idle(4);
  endtask

  task automatic test_abort();
    drive(1'b1, 1'b1, 1'b0, 2'b11, START + 32'h10, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'b11, START, 32'd0);
    idle(5);
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 1'b1, 1'b0, 2'b11, START + 32'h4, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2'b11, START + 32'h10, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0; stb = 1'b0;
    sbq.delete();
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ack_s[k] !== 1'b0 || err_s[k] !== 1'b0) begin
        errors++;
        $display("FAIL midreset inst%0d: ack=%0b err=%0b, want 0 0", k, ack_s[k], err_s[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    drive(1'b1, 1'b1, 1'b0, 2'b00, START + 32'h13, 32'd0);
    idle(4);
  endtask

  task automatic test_random();
    int          r;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int n = 0; n < 120; n++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : ((r < 6) ? 2'b01 : ((r < 9) ? 2'b11 : 2'b10));
      a  = START + 32'($urandom_range(0, SIZE - 1));
      if ($urandom_range(0, 3) != 0) a[1:0] = (sz == 2'b01) ? {a[1], 1'b0} : ((sz == 2'b11) ? 2'b00 : a[1:0]);
      if ($urandom_range(0, 9) == 0) a = START + 32'(SIZE) + 32'($urandom_range(0, 15));
      drive($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            sz, a, $urandom);
    end
    idle(5);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, want 0", sbq.size());
    end
  endtask

  initial begin
    logic [31:0] w;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1024; i++) begin
        w = init_word(i);
        for (int b = 0; b < 4; b++) refm[k][4*i+b] = w[8*b +: 8];
      end
    end
    test_reset();
    test_word_rw();
    test_back_to_back();
    test_half();
    test_errors();
    test_abort();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
